// File: rtl/sign_pkg.sv
// Shared types for the sign narrowing block: FIFO occupancy encoding and overflow counter sizing.
package sign_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } occ_t;

  localparam int CNT_W = 8;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

endpackage

// File: rtl/sign_narrow_core.sv
// Combinational signed narrowing IN_W -> OUT_W with overflow flag; saturates (SAT=1) or wraps (SAT=0).
module sign_narrow_core #(
  parameter int IN_W  = 8,
  parameter int OUT_W = 2,
  parameter int SAT   = 1
) (
  input  logic [IN_W-1:0]  in_data,
  output logic [OUT_W-1:0] out_data,
  output logic             ovf
);

  // Every bit from the sign down to the new sign position must agree for the value to fit.
  logic [IN_W-OUT_W:0] top_bits;
  assign top_bits = in_data[IN_W-1:OUT_W-1];
  assign ovf      = !((&top_bits) || !(|top_bits));

  always_comb begin
    out_data = in_data[OUT_W-1:0];
    if (ovf && (SAT != 0)) begin
      out_data = {in_data[IN_W-1], {(OUT_W-1){~in_data[IN_W-1]}}};
    end
  end

endmodule

// File: rtl/sign_narrow.sv
// Narrows accepted beats into a 2-entry FIFO; 1-cycle accept-to-valid latency when empty.
// in_ready is registered and drops only when both entries are occupied.
module sign_narrow
  import sign_pkg::*;
#(
  parameter int IN_W  = 8,
  parameter int OUT_W = 2,
  parameter int SAT   = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IN_W-1:0]  in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_ovf,
  output logic             out_valid,
  input  logic             out_ready,
  input  logic             ovf_clr,
  output logic [CNT_W-1:0] ovf_cnt
);

  logic [OUT_W-1:0] nar_data;
  logic             nar_ovf;
  logic [OUT_W:0]   nar_ent;
  logic [OUT_W:0]   slot0;
  logic [OUT_W:0]   slot1;
  logic             push;
  logic             pop;
  occ_t             state;
  occ_t             state_nxt;

  sign_narrow_core #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W),
    .SAT   (SAT)
  ) u_core (
    .in_data  (in_data),
    .out_data (nar_data),
    .ovf      (nar_ovf)
  );

  assign nar_ent   = {nar_data, nar_ovf};
  assign out_valid = (state != ST_EMPTY);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign out_data  = slot0[OUT_W:1];
  assign out_ovf   = slot0[0];

  always_comb begin
    state_nxt = state;
    case (state)
      ST_EMPTY: if (push) state_nxt = ST_ONE;
      ST_ONE: begin
        if (push && !pop)      state_nxt = ST_FULL;
        else if (!push && pop) state_nxt = ST_EMPTY;
      end
      ST_FULL:  if (pop) state_nxt = ST_ONE;
      default:  state_nxt = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_EMPTY;
      in_ready <= 1'b0;
    end else begin
      state    <= state_nxt;
      in_ready <= (state_nxt != ST_FULL);
    end
  end

  // slot0 always holds the oldest entry, so the output needs no read mux.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot0 <= '0;
      slot1 <= '0;
    end else begin
      case (state)
        ST_EMPTY: if (push) slot0 <= nar_ent;
        ST_ONE: begin
          if (push && pop) slot0 <= nar_ent;
          else if (push)   slot1 <= nar_ent;
        end
        ST_FULL:  if (pop) slot0 <= slot1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_cnt <= '0;
    end else if (ovf_clr) begin
      ovf_cnt <= (push && nar_ovf) ? CNT_W'(1) : '0;
    end else if (push && nar_ovf && (ovf_cnt != CNT_MAX)) begin
      ovf_cnt <= ovf_cnt + CNT_W'(1);
    end
  end

endmodule
